// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: arbiter FSM state type and port index constants shared by the ram_arbiter slice
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two requester ports (req/lock/wr/addr/wdata in, gnt/rvalid/rdata out); master = requesters, slave = arbiter
interface ram_arbiter_if #(parameter int AW = 3, parameter int DW = 8);
  logic req0, lock0, wr0, gnt0, rvalid0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic req1, lock1, wr1, gnt1, rvalid1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1, rdata1;
  modport master(
    output req0, lock0, wr0, addr0, wdata0, req1, lock1, wr1, addr1, wdata1,
    input gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
  );
  modport slave(
    input req0, lock0, wr0, addr0, wdata0, req1, lock1, wr1, addr1, wdata1,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1
  );
endinterface

// File: rtl/ram8x8.sv
// ram8x8: single-port RAM, synchronous write and registered read on en (ports clk, en, wr, addr, wdata, rdata)
module ram8x8 #(parameter int AW = 3, parameter int DW = 8) (
  input  logic          clk,
  input  logic          en,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (en) begin
      if (wr) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter with bounded lock sharing one ram8x8 between two ports (clk, sync active-low nrst, bus slave)
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW      = 3,
  parameter int DW      = 8,
  parameter int MAXHOLD = 4
) (
  input logic           clk,
  input logic           nrst,
  ram_arbiter_if.slave  bus
);
  localparam int HW = $clog2(MAXHOLD + 1);
  arb_state_t    state, state_n;
  logic          last, forced, g, win, wr, rv0, rv1;
  logic [HW-1:0] hc;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, q, h0, h1;
  always_comb begin
    forced    = hc == HW'(MAXHOLD) && (last == P0 ? bus.req1 : bus.req0);
    g         = nrst && (bus.req0 || bus.req1);
    win       = (state == OWN0 && bus.req0 && !forced) ? P0 :
                (state == OWN1 && bus.req1 && !forced) ? P1 :
                (bus.req0 && bus.req1) ? ~last :
                bus.req1 ? P1 : P0;
    bus.gnt0  = g && win == P0;
    bus.gnt1  = g && win == P1;
    wr        = win ? bus.wr1 : bus.wr0;
    addr      = win ? bus.addr1 : bus.addr0;
    wdata     = win ? bus.wdata1 : bus.wdata0;
    state_n   = !g ? IDLE :
                win ? (bus.lock1 ? OWN1 : IDLE) : (bus.lock0 ? OWN0 : IDLE);
  end
  ram8x8 #(.AW(AW), .DW(DW)) u_ram (
    .clk(clk), .en(g), .wr(wr), .addr(addr), .wdata(wdata), .rdata(q)
  );
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      last  <= P1;
      hc    <= '0;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
      h0    <= '0;
      h1    <= '0;
    end else begin
      state <= state_n;
      if (g) last <= win;
      hc    <= !g ? '0 :
               (win == last && hc != '0) ? (hc == HW'(MAXHOLD) ? hc : hc + 1'b1) : HW'(1);
      rv0   <= bus.gnt0 && !bus.wr0;
      rv1   <= bus.gnt1 && !bus.wr1;
      if (rv0) h0 <= q;
      if (rv1) h1 <= q;
    end
  end
  // RAM output is live only in the cycle after a read; otherwise show the held copy
  assign bus.rvalid0 = rv0;
  assign bus.rvalid1 = rv1;
  assign bus.rdata0  = rv0 ? q : h0;
  assign bus.rdata1  = rv1 ? q : h1;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random stimulus with a scoreboard of expected read data checked by a monitor
module tb_ram_arbiter;
  localparam int MAXHOLD = 4;
  logic clk = 0, nrst = 0;
  always #5 clk = ~clk;
  ram_arbiter_if #(.AW(3), .DW(8)) bus();
  ram_arbiter #(.AW(3), .DW(8), .MAXHOLD(MAXHOLD)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  typedef struct {logic [7:0] d; int due;} exp_t;
  exp_t q[2][$];
  int tests = 0, fails = 0, mcyc = 0;
  logic r[2], l[2], w[2];
  logic [2:0] a[2];
  logic [7:0] d[2];
  logic [7:0] mem[8];
  int lastw = 1, run = 0, lockp = -1, gw;
  logic [9:0] pat3 = 10'b1111101111;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic int pick();
    bit forced = run >= MAXHOLD && r[1-lastw];
    if (lockp >= 0 && r[lockp] && !forced) return lockp;
    if (r[0] && r[1]) return 1 - lastw;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction
  task automatic step(input logic n);
    @(negedge clk);
    nrst = n;
    bus.req0 = r[0]; bus.lock0 = l[0]; bus.wr0 = w[0]; bus.addr0 = a[0]; bus.wdata0 = d[0];
    bus.req1 = r[1]; bus.lock1 = l[1]; bus.wr1 = w[1]; bus.addr1 = a[1]; bus.wdata1 = d[1];
    #1;
    gw = n ? pick() : -1;
    chk("gnt0", bus.gnt0, gw == 0);
    chk("gnt1", bus.gnt1, gw == 1);
    if (!n) begin
      lastw = 1; run = 0; lockp = -1;
    end else if (gw < 0) begin
      run = 0; lockp = -1;
    end else begin
      run = (gw == lastw && run > 0) ? (run < MAXHOLD ? run + 1 : run) : 1;
      lastw = gw;
      lockp = l[gw] ? gw : -1;
      if (w[gw]) mem[a[gw]] = d[gw];
      else q[gw].push_back('{mem[a[gw]], mcyc + 1});
      r[gw] = 0;
    end
  endtask
  initial forever begin
    @(posedge clk);
    mcyc++;
    #2;
    for (int p = 0; p < 2; p++) begin
      logic v;
      logic [7:0] rd;
      v = p ? bus.rvalid1 : bus.rvalid0;
      rd = p ? bus.rdata1 : bus.rdata0;
      if (q[p].size() > 0 && q[p][0].due == mcyc) begin
        chk($sformatf("rvalid%0d", p), v, 1);
        if (v) chk($sformatf("rdata%0d", p), rd, q[p][0].d);
        void'(q[p].pop_front());
      end else if (v) chk($sformatf("spurious rvalid%0d", p), v, 0);
    end
  end
  initial begin
    for (int p = 0; p < 2; p++) begin
      r[p] = 0; l[p] = 0; w[p] = 0; a[p] = 0; d[p] = 0;
    end
    step(0); step(0); step(1);
    chk("rst rvalid0", bus.rvalid0, 0);
    chk("rst rvalid1", bus.rvalid1, 0);
    chk("rst rdata0", bus.rdata0, 0);
    chk("rst rdata1", bus.rdata1, 0);
    r[0] = 1; w[0] = 1; a[0] = 3; d[0] = 8'h5A;
    step(1); chk("t1 wr gnt", gw, 0);
    r[0] = 1; w[0] = 0;
    step(1); chk("t1 rd gnt", gw, 0);
    step(1);
    chk("t1 rvalid0", bus.rvalid0, 1);
    chk("t1 rdata0", bus.rdata0, 8'h5A);
    for (int i = 0; i < 8; i++) begin
      r[0] = 1; w[0] = 1; a[0] = 3'(i); d[0] = 8'((i + 1) * 8'h11);
      step(1);
    end
    for (int i = 0; i < 8; i++) begin
      r[1] = 1; w[1] = 0; a[1] = 3'(i);
      step(1);
      if (i > 0) chk("t5 rdata1", bus.rdata1, 8'(i * 8'h11));
    end
    step(1);
    chk("t5 last rdata1", bus.rdata1, 8'h88);
    step(0);
    w[0] = 0; w[1] = 0; a[0] = 1; a[1] = 6;
    for (int i = 0; i < 8; i++) begin
      r[0] = 1; r[1] = 1;
      step(1); chk("t2 alternate", gw, i % 2);
    end
    r[0] = 0; r[1] = 0;
    step(1); step(1);
    l[1] = 1; a[0] = 2;
    for (int i = 0; i < 10; i++) begin
      r[1] = 1;
      if (i == 2) r[0] = 1;
      step(1); chk("t3 lock pattern", gw == 1, pat3[i]);
    end
    l[1] = 0; r[1] = 0; r[0] = 0;
    step(1);
    r[1] = 1; l[1] = 1;
    step(1); chk("t4 lock grant", gw, 1);
    r[1] = 0; l[1] = 0; r[0] = 1;
    step(1); chk("t4 release", gw, 0);
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!r[p] && $urandom_range(0, 3) != 0) begin
          r[p] = 1; l[p] = 1'($urandom); w[p] = 1'($urandom);
          a[p] = 3'($urandom); d[p] = 8'($urandom);
        end
      step($urandom_range(0, 60) != 0);
    end
    r[0] = 0; r[1] = 0; l[0] = 0; l[1] = 0;
    step(1); step(1);
    r[1] = 1; w[1] = 0; a[1] = 5;
    step(0);
    r[0] = 1; w[0] = 0; a[0] = 2;
    step(1); chk("t6 first tie", gw, 0);
    chk("t6 no rvalid1", bus.rvalid1, 0);
    step(1); chk("t6 then port1", gw, 1);
    step(1); step(1); step(1);
    chk("drain", q[0].size() + q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
